regfile_banked: RTL and testbench

Parametrised successor to the integer/FP register file in the DLX datapath. It provides two banks of 2**ADDR_W registers: integer (GPR) and floating-point (FPR). It has one write port, two read ports, optional write-to-read bypass and double-precision register-pair access. It also keeps a per-register pending-write scoreboard, which the decode stage uses to stall on RAW hazards.

---
 rtl/regfile_banked.sv | 133 +++++++++++++
 tb/tb_regfile_banked.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_banked.sv
// rtl/regfile_banked.sv - banked GPR/FPR register file with write bypass, pair access and pending-write scoreboard
`timescale 1ns/1ps
module regfile_banked #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_fp,
  input  logic                 wr_dbl,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic                 rd_fp1,
  input  logic                 rd_fp2,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  output logic [WIDTH-1:0]     rd_data1,
  output logic [WIDTH-1:0]     rd_data2,
  output logic [WIDTH-1:0]     rd_pair1,
  output logic [WIDTH-1:0]     rd_pair2,
  input  logic                 busy_set,
  input  logic                 busy_fp,
  input  logic                 busy_dbl,
  input  logic [ADDR_W-1:0]    busy_addr,
  output logic                 busy1,
  output logic                 busy2
);

  localparam int NREG = 2**ADDR_W;

  logic [WIDTH-1:0]  gpr [NREG];
  logic [WIDTH-1:0]  fpr [NREG];
  logic [NREG-1:0]   gpr_busy;
  logic [NREG-1:0]   fpr_busy;
  logic [NREG-1:0]   gpr_we;
  logic [NREG-1:0]   fpr_we;
  logic [NREG-1:0]   gpr_bs;
  logic [NREG-1:0]   fpr_bs;
  logic              wr_pair;
  logic              bs_pair;
  logic [WIDTH-1:0]  wr_hi;
  logic [WIDTH-1:0]  wr_lo;

  // Pair operations only exist in the FPR bank; a GPR "double" degrades to a single access.
  assign wr_pair = wr_fp & wr_dbl;
  assign bs_pair = busy_fp & busy_dbl;
  assign wr_hi   = wr_data[2*WIDTH-1:WIDTH];
  assign wr_lo   = wr_data[WIDTH-1:0];

  function automatic logic hit(input logic pair, input logic [ADDR_W-1:0] a,
                               input logic [ADDR_W-1:0] r);
    return pair ? ((a >> 1) == (r >> 1)) : (a == r);
  endfunction

  always_comb begin
    gpr_we = '0;
    fpr_we = '0;
    gpr_bs = '0;
    fpr_bs = '0;
    for (int i = 0; i < NREG; i++) begin
      gpr_we[i] = wr_en && !wr_fp && (wr_addr == ADDR_W'(i));
      fpr_we[i] = wr_en && wr_fp && hit(wr_pair, wr_addr, ADDR_W'(i));
      gpr_bs[i] = busy_set && !busy_fp && (busy_addr == ADDR_W'(i));
      fpr_bs[i] = busy_set && busy_fp && hit(bs_pair, busy_addr, ADDR_W'(i));
    end
    if (ZERO_R0) begin
      gpr_we[0] = 1'b0;
      gpr_bs[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
        fpr[i] <= '0;
      end
      gpr_busy <= '0;
      fpr_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (gpr_we[i]) gpr[i] <= wr_lo;
        // Even register of a pair takes the high word.
        if (fpr_we[i]) fpr[i] <= (wr_pair && !i[0]) ? wr_hi : wr_lo;
      end
      // A new issue owns the register, so a set beats a same-cycle completion.
      gpr_busy <= gpr_bs | (gpr_busy & ~gpr_we);
      fpr_busy <= fpr_bs | (fpr_busy & ~fpr_we);
    end
  end

  logic              ch_fp [4];
  logic [ADDR_W-1:0] ch_a  [4];
  logic [WIDTH-1:0]  ch_q  [4];

  assign ch_fp[0] = rd_fp1;
  assign ch_a[0]  = rd_addr1;
  assign ch_fp[1] = rd_fp1;
  assign ch_a[1]  = rd_addr1 | ADDR_W'(1);
  assign ch_fp[2] = rd_fp2;
  assign ch_a[2]  = rd_addr2;
  assign ch_fp[3] = rd_fp2;
  assign ch_a[3]  = rd_addr2 | ADDR_W'(1);

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      ch_q[c] = '0;
      if (ch_fp[c]) begin
        ch_q[c] = fpr[ch_a[c]];
        if (BYPASS && fpr_we[ch_a[c]])
          ch_q[c] = (wr_pair && !ch_a[c][0]) ? wr_hi : wr_lo;
      end else begin
        ch_q[c] = gpr[ch_a[c]];
        if (BYPASS && gpr_we[ch_a[c]])
          ch_q[c] = wr_lo;
      end
      // The bypass path must not leak incoming data while reset is held.
      if (!rst) ch_q[c] = '0;
    end
  end

  assign rd_data1 = ch_q[0];
  assign rd_pair1 = ch_q[1];
  assign rd_data2 = ch_q[2];
  assign rd_pair2 = ch_q[3];

  assign busy1 = rd_fp1 ? fpr_busy[rd_addr1] : gpr_busy[rd_addr1];
  assign busy2 = rd_fp2 ? fpr_busy[rd_addr2] : gpr_busy[rd_addr2];

endmodule

// File: tb/tb_regfile_banked.sv
// tb/tb_regfile_banked.sv - self-checking bench for regfile_banked
`timescale 1ns/1ps
module tb_regfile_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_fp, wr_dbl;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_fp1, rd_fp2;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        busy_set, busy_fp, busy_dbl;
  logic [4:0]  busy_addr;

  logic [31:0] bd1, bd2, bp1, bp2, nd1, nd2, np1, np2;
  logic        bb1, bb2, nb1, nb2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_banked #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_fp(wr_fp), .wr_dbl(wr_dbl),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_fp1(rd_fp1), .rd_fp2(rd_fp2),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(bd1), .rd_data2(bd2),
    .rd_pair1(bp1), .rd_pair2(bp2), .busy_set(busy_set), .busy_fp(busy_fp),
    .busy_dbl(busy_dbl), .busy_addr(busy_addr), .busy1(bb1), .busy2(bb2));

  regfile_banked #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_fp(wr_fp), .wr_dbl(wr_dbl),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_fp1(rd_fp1), .rd_fp2(rd_fp2),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(nd1), .rd_data2(nd2),
    .rd_pair1(np1), .rd_pair2(np2), .busy_set(busy_set), .busy_fp(busy_fp),
    .busy_dbl(busy_dbl), .busy_addr(busy_addr), .busy1(nb1), .busy2(nb2));

  // Reference model: bank 0 = GPR, bank 1 = FPR.
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 32; r++) begin
          m_reg[b][r]  <= '0;
          m_busy[b][r] <= 1'b0;
        end
    end else begin
      if (wr_en) begin
        if (wr_fp && wr_dbl) begin
          m_reg[1][int'(wr_addr) & ~1]      <= wr_data[63:32];
          m_reg[1][(int'(wr_addr) & ~1) + 1] <= wr_data[31:0];
          m_busy[1][int'(wr_addr) & ~1]      <= 1'b0;
          m_busy[1][(int'(wr_addr) & ~1) + 1] <= 1'b0;
        end else if (wr_fp || wr_addr != 0) begin
          m_reg[wr_fp][wr_addr]  <= wr_data[31:0];
          m_busy[wr_fp][wr_addr] <= 1'b0;
        end
      end
      if (busy_set) begin
        if (busy_fp && busy_dbl) begin
          m_busy[1][int'(busy_addr) & ~1]       <= 1'b1;
          m_busy[1][(int'(busy_addr) & ~1) + 1] <= 1'b1;
        end else if (busy_fp || busy_addr != 0) begin
          m_busy[busy_fp][busy_addr] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input bit byp, input bit fp, input int a);
    int base;
    base = int'(wr_addr) & ~1;
    if (!rst) return 32'h0;
    if (!fp && a == 0) return 32'h0;
    if (byp && wr_en) begin
      if (wr_fp && wr_dbl) begin
        if (fp && a == base)     return wr_data[63:32];
        if (fp && a == base + 1) return wr_data[31:0];
      end else if (fp == wr_fp && a == int'(wr_addr)) begin
        return wr_data[31:0];
      end
    end
    return m_reg[fp][a];
  endfunction

  function automatic logic [31:0] exp_busy(input bit fp, input int a);
    if (!rst) return 32'h0;
    return {31'h0, m_busy[fp][a]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_bdata1", bd1, exp_word(1'b1, rd_fp1, int'(rd_addr1)));
    chk("m_bpair1", bp1, exp_word(1'b1, rd_fp1, int'(rd_addr1) | 1));
    chk("m_bdata2", bd2, exp_word(1'b1, rd_fp2, int'(rd_addr2)));
    chk("m_bpair2", bp2, exp_word(1'b1, rd_fp2, int'(rd_addr2) | 1));
    chk("m_ndata1", nd1, exp_word(1'b0, rd_fp1, int'(rd_addr1)));
    chk("m_npair1", np1, exp_word(1'b0, rd_fp1, int'(rd_addr1) | 1));
    chk("m_ndata2", nd2, exp_word(1'b0, rd_fp2, int'(rd_addr2)));
    chk("m_npair2", np2, exp_word(1'b0, rd_fp2, int'(rd_addr2) | 1));
    chk("m_bbusy1", {31'h0, bb1}, exp_busy(rd_fp1, int'(rd_addr1)));
    chk("m_bbusy2", {31'h0, bb2}, exp_busy(rd_fp2, int'(rd_addr2)));
    chk("m_nbusy1", {31'h0, nb1}, exp_busy(rd_fp1, int'(rd_addr1)));
    chk("m_nbusy2", {31'h0, nb2}, exp_busy(rd_fp2, int'(rd_addr2)));
  end

  task automatic idle();
    wr_en = 1'b0; wr_fp = 1'b0; wr_dbl = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_fp = 1'b0; busy_dbl = 1'b0; busy_addr = '0;
  endtask

  task automatic wr(input bit fp, input bit dbl, input int a, input logic [63:0] d);
    wr_en = 1'b1; wr_fp = fp; wr_dbl = dbl; wr_addr = a[4:0]; wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input bit f1, input int a1, input bit f2, input int a2);
    rd_fp1 = f1; rd_addr1 = a1[4:0]; rd_fp2 = f2; rd_addr2 = a2[4:0];
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd(1'b0, 3, 1'b0, 3);
    wr(1'b0, 1'b0, 3, 64'h1111);
    busy_set = 1'b1; busy_addr = 5'd3;
    #2;
    chk("rst_data1", bd1, 32'h0);
    chk("rst_busy1", {31'h0, bb1}, 32'h0);
    tick();
    tick();

    rst = 1'b1;
    idle();
    wr(1'b0, 1'b0, 1, 64'h2ae42);    tick();
    wr(1'b0, 1'b0, 2, 64'h32137);    tick();
    wr(1'b0, 1'b0, 3, 64'h8b004e);   tick();
    wr(1'b0, 1'b0, 4, 64'hfde546);   tick();
    idle();
    rd(1'b0, 1, 1'b0, 2);
    #1;
    chk("gpr1", bd1, 32'h2ae42);
    chk("gpr2", nd2, 32'h32137);
    tick();
    rd(1'b0, 3, 1'b0, 4);
    #1;
    chk("gpr3", nd1, 32'h8b004e);
    chk("gpr4", bd2, 32'hfde546);
    chk("busy_after_rst", {31'h0, bb1}, 32'h0);
    tick();

    wr(1'b0, 1'b0, 0, 64'hdeadbeef); tick();
    wr(1'b1, 1'b0, 0, 64'h3f800000); tick();
    wr(1'b0, 1'b0, 5, 64'h5555);     tick();
    wr(1'b1, 1'b0, 5, 64'haaaa);     tick();
    idle();
    rd(1'b0, 0, 1'b1, 0);
    #1;
    chk("gpr0_zero", bd1, 32'h0);
    chk("fpr0", bd2, 32'h3f800000);
    tick();
    rd(1'b0, 5, 1'b1, 5);
    #1;
    chk("gpr5", bd1, 32'h5555);
    chk("fpr5", bd2, 32'haaaa);
    tick();

    wr(1'b1, 1'b1, 5, 64'h400921fb_54442d18); tick();
    idle();
    rd(1'b1, 4, 1'b1, 5);
    #1;
    chk("dbl_hi", bd1, 32'h400921fb);
    chk("dbl_lo", bp1, 32'h54442d18);
    chk("dbl_odd", nd2, 32'h54442d18);
    tick();

    rd(1'b0, 7, 1'b0, 0);
    wr(1'b0, 1'b0, 7, 64'h12345678);
    #1;
    chk("byp_on", bd1, 32'h12345678);
    chk("byp_off", nd1, 32'h0);
    tick();
    idle();
    #1;
    chk("byp_off_after", nd1, 32'h12345678);
    tick();

    rd(1'b1, 31, 1'b1, 30);
    wr(1'b1, 1'b1, 31, 64'hcafef00d_0badc0de);
    #1;
    chk("dbyp_lo", bd1, 32'h0badc0de);
    chk("dbyp_hi", bd2, 32'hcafef00d);
    chk("dbyp_pair", bp2, 32'h0badc0de);
    chk("dbyp_off", nd2, 32'h0);
    tick();
    idle();
    rd(1'b1, 31, 1'b1, 0);
    #1;
    chk("dtop_lo", nd1, 32'h0badc0de);
    chk("no_wrap", nd2, 32'h3f800000);
    tick();

    rd(1'b1, 2, 1'b1, 3);
    busy_set = 1'b1; busy_fp = 1'b1; busy_dbl = 1'b1; busy_addr = 5'd2;
    #1;
    chk("busy_not_yet", {31'h0, bb1}, 32'h0);
    tick();
    idle();
    #1;
    chk("busy_f2", {31'h0, bb1}, 32'h1);
    chk("busy_f3", {31'h0, bb2}, 32'h1);
    wr(1'b1, 1'b0, 2, 64'h77);
    #1;
    chk("busy_no_bypass", {31'h0, bb1}, 32'h1);
    tick();
    idle();
    #1;
    chk("busy_f2_clr", {31'h0, nb1}, 32'h0);
    chk("busy_f3_keep", {31'h0, nb2}, 32'h1);
    tick();

    rd(1'b0, 9, 1'b0, 0);
    wr(1'b0, 1'b0, 9, 64'h99);
    busy_set = 1'b1; busy_fp = 1'b0; busy_addr = 5'd9;
    tick();
    idle();
    #1;
    chk("set_wins", {31'h0, bb1}, 32'h1);
    chk("set_wins_data", nd1, 32'h99);
    busy_set = 1'b1; busy_fp = 1'b0; busy_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("r0_never_busy", {31'h0, bb2}, 32'h0);

    rd(1'b0, 10, 1'b0, 11);
    wr(1'b0, 1'b0, 10, 64'hab);
    busy_set = 1'b1; busy_fp = 1'b0; busy_addr = 5'd11;
    tick();
    idle();
    #1;
    chk("indep_data", nd1, 32'hab);
    chk("indep_busy10", {31'h0, bb1}, 32'h0);
    chk("indep_busy11", {31'h0, bb2}, 32'h1);
    tick();

    rd(1'b0, 9, 1'b1, 4);
    #1;
    chk("pre_rst_busy", {31'h0, bb1}, 32'h1);
    chk("pre_rst_data", bd2, 32'h400921fb);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'h0, bb1}, 32'h0);
    chk("arst_data1", bd1, 32'h0);
    chk("arst_data2", nd2, 32'h0);
    chk("arst_pair2", bp2, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("post_rst_data", nd2, 32'h0);
    chk("post_rst_busy", {31'h0, nb1}, 32'h0);
    wr(1'b0, 1'b0, 9, 64'h123);
    tick();
    idle();
    #1;
    chk("post_rst_write", nd1, 32'h123);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
